// File: rtl/dotp_pkg.sv
// Shared types and constants for the dot-product read engine.
// DOTP_SIGNED_EN (consumed in dotp_mac) selects two's-complement arithmetic.
package dotp_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    // Cycles between the last read issue and the done pulse: one for the
    // memory read latency and one for the product register.
    localparam int DRAIN_CYCLES = 2;
    localparam int DRAIN_CNT_W  = 2;
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Full-length sum of max-valued products never overflows this width.
    function automatic int acc_width(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/dotp_mac.sv
// Valid-qualified multiply register followed by an accumulator with synchronous clear.
// DOTP_SIGNED_EN defined: signed operands/product/accumulation; otherwise unsigned.
module dotp_mac
    import dotp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc_next
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        w_a_ext;
    logic [PW-1:0]        w_b_ext;
    logic [PW-1:0]        w_prod;
    logic [ACC_WIDTH-1:0] w_prod_ext;
    logic [ACC_WIDTH-1:0] w_acc_next;

    logic [PW-1:0]        r_prod;
    logic                 r_prod_vld;
    logic [ACC_WIDTH-1:0] r_acc;

`ifdef DOTP_SIGNED_EN
    assign w_a_ext    = PW'($signed(i_a));
    assign w_b_ext    = PW'($signed(i_b));
    assign w_prod_ext = ACC_WIDTH'($signed(r_prod));
`else
    assign w_a_ext    = PW'(i_a);
    assign w_b_ext    = PW'(i_b);
    assign w_prod_ext = ACC_WIDTH'(r_prod);
`endif

    // Low PW bits of the extended product are the exact full-width product.
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_acc_next = r_prod_vld ? (r_acc + w_prod_ext) : r_acc;
    assign o_acc_next = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= i_vld;
            if (i_vld) begin
                r_prod <= w_prod;
            end
            if (i_clr) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end
    end

endmodule

// File: rtl/dotp_engine.sv
// dotp_engine: streams len operand pairs from two mem1 read ports and returns their dot product.
// Arithmetic signedness follows DOTP_SIGNED_EN (see dotp_mac).
module dotp_engine
    import dotp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    output logic                  rd_en_a,
    output logic                  rd_en_b,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  result,
    output state_e                o_dbg_state
);

    state_e                  r_state;
    logic                    r_rd_en;
    logic                    r_rd_vld;
    logic [ADDR_WIDTH-1:0]   r_addr_a;
    logic [ADDR_WIDTH-1:0]   r_addr_b;
    logic [ADDR_WIDTH:0]     r_cnt;
    logic [DRAIN_CNT_W-1:0]  r_drain;
    logic                    r_busy;
    logic                    r_done;
    logic [ACC_WIDTH-1:0]    r_result;

    logic                    w_accept;
    logic [ACC_WIDTH-1:0]    w_acc_next;

    // start is a single-cycle request with no ready handshake: it is taken
    // whenever the engine is idle or in its done cycle, and dropped otherwise.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_en  <= 1'b0;
            r_rd_vld <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_cnt    <= '0;
            r_drain  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_rd_vld <= r_rd_en;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept && (len == '0)) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= '0;
                    end else if (w_accept) begin
                        r_state  <= S_READ;
                        r_busy   <= 1'b1;
                        r_rd_en  <= 1'b1;
                        r_addr_a <= base_a;
                        r_addr_b <= base_b;
                        r_cnt    <= len - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    // r_cnt counts reads still to issue after the current one.
                    if (r_cnt == '0) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                        r_drain <= DRAIN_LAST;
                    end else begin
                        r_cnt    <= r_cnt - 1'b1;
                        r_addr_a <= r_addr_a + 1'b1;
                        r_addr_b <= r_addr_b + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_acc_next;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    dotp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_accept),
        .i_vld      (r_rd_vld),
        .i_a        (rd_data_a),
        .i_b        (rd_data_b),
        .o_acc_next (w_acc_next)
    );

    assign rd_en_a     = r_rd_en;
    assign rd_en_b     = r_rd_en;
    assign rd_addr_a   = r_addr_a;
    assign rd_addr_b   = r_addr_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dotp_engine.sv
// Directed bench for dotp_engine with two behavioural one-cycle-latency operand memories.
// Compile with +define+DOTP_SIGNED_EN to check the signed build.
module tb_dotp_engine;
    import dotp_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int ACCW = 2 * DW + AW;
    localparam int NTR  = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW:0]     len = '0;
    logic [AW-1:0]   base_a = '0;
    logic [AW-1:0]   base_b = '0;
    logic            rd_en_a, rd_en_b;
    logic [AW-1:0]   rd_addr_a, rd_addr_b;
    logic [DW-1:0]   rd_data_a, rd_data_b;
    logic            busy, done;
    logic [ACCW-1:0] result;
    state_e          dbg_state;

    logic [DW-1:0]   mem_a [16];
    logic [DW-1:0]   mem_b [16];

    logic            tr_en   [NTR];
    logic [AW-1:0]   tr_aa   [NTR];
    logic [AW-1:0]   tr_ab   [NTR];
    logic            tr_busy [NTR];
    logic            tr_done [NTR];
    logic [ACCW-1:0] tr_res  [NTR];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dotp_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ACC_WIDTH  (ACCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .base_a      (base_a),
        .base_b      (base_b),
        .rd_en_a     (rd_en_a),
        .rd_en_b     (rd_en_b),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .o_dbg_state (dbg_state)
    );

    // Registered read ports standing in for the two mem1 instances.
    always @(posedge clk) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
            if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
        end
    end

    function automatic logic [ACCW-1:0] model(input int l, input int ba, input int bb);
        logic [ACCW-1:0] s;
        int x, y;
        s = '0;
        for (int i = 0; i < l; i++) begin
`ifdef DOTP_SIGNED_EN
            x = $signed(mem_a[(ba + i) % 16]);
            y = $signed(mem_b[(bb + i) % 16]);
`else
            x = mem_a[(ba + i) % 16];
            y = mem_b[(bb + i) % 16];
`endif
            s = s + ACCW'(x * y);
        end
        return s;
    endfunction

    // Called #1 after an edge; returns #1 after the edge that sampled start (cycle 1).
    task automatic do_start(input int l, input int ba, input int bb);
        start  = 1'b1;
        len    = (AW+1)'(l);
        base_a = AW'(ba);
        base_b = AW'(bb);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Captures outputs for cycles 1..ncyc; optionally raises start in cycle inj.
    task automatic record(input int ncyc, input int inj, input int inj_len, input int inj_base);
        for (int c = 1; c <= ncyc; c++) begin
            tr_en[c]   = rd_en_a & rd_en_b;
            tr_aa[c]   = rd_addr_a;
            tr_ab[c]   = rd_addr_b;
            tr_busy[c] = busy;
            tr_done[c] = done;
            tr_res[c]  = result;
            if (c == inj) begin
                start  = 1'b1;
                len    = (AW+1)'(inj_len);
                base_a = AW'(inj_base);
                base_b = AW'(inj_base);
            end
            @(posedge clk); #1;
            if (c == inj) start = 1'b0;
        end
    endtask

    function automatic int first_done(input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            if (tr_done[c]) return c;
        end
        return -1;
    endfunction

    function automatic int count_done(input int ncyc);
        int n;
        n = 0;
        for (int c = 1; c <= ncyc; c++) n += int'(tr_done[c]);
        return n;
    endfunction

    task automatic test_reset();
        n_cmp++; if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b%b want 00", rd_en_a, rd_en_b); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (rd_addr_a !== '0 || rd_addr_b !== '0) begin n_err++; $display("FAIL reset_addr got %h/%h want 0/0", rd_addr_a, rd_addr_b); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    endtask

    task automatic test_single();
        int dc;
        mem_a[0] = 8'h11; mem_b[0] = 8'h22;
        do_start(1, 0, 0);
        record(6, 0, 0, 0);
        dc = first_done(6);
        n_cmp++; if (tr_en[1] !== 1'b1) begin n_err++; $display("FAIL single_en_c1 got %b want 1", tr_en[1]); end
        n_cmp++; if (tr_en[2] !== 1'b0) begin n_err++; $display("FAIL single_en_c2 got %b want 0", tr_en[2]); end
        n_cmp++; if (tr_aa[1] !== 4'd0 || tr_ab[1] !== 4'd0) begin n_err++; $display("FAIL single_addr got %0d/%0d want 0/0", tr_aa[1], tr_ab[1]); end
        n_cmp++; if (dc !== 4) begin n_err++; $display("FAIL single_done_cycle got %0d want 4", dc); end
        n_cmp++; if (tr_res[4] !== 20'h00242) begin n_err++; $display("FAIL single_result got %h want 00242", tr_res[4]); end
        n_cmp++; if (tr_done[5] !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got %b want 0", tr_done[5]); end
    endtask

    task automatic test_len4();
        int dc;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        do_start(4, 0, 0);
        record(9, 0, 0, 0);
        dc = first_done(9);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (tr_en[c] !== 1'b1 || tr_aa[c] !== AW'(c - 1) || tr_ab[c] !== AW'(c - 1)) begin
                n_err++; $display("FAIL len4_read_c%0d got en=%b a=%0d b=%0d want en=1 a=%0d b=%0d", c, tr_en[c], tr_aa[c], tr_ab[c], c - 1, c - 1);
            end
        end
        n_cmp++; if (tr_en[5] !== 1'b0) begin n_err++; $display("FAIL len4_en_c5 got %b want 0", tr_en[5]); end
        for (int c = 1; c <= 7; c++) begin
            n_cmp++;
            if (tr_busy[c] !== (c <= 6)) begin n_err++; $display("FAIL len4_busy_c%0d got %b want %b", c, tr_busy[c], (c <= 6)); end
        end
        n_cmp++; if (dc !== 7) begin n_err++; $display("FAIL len4_done_cycle got %0d want 7", dc); end
        n_cmp++; if (tr_res[7] !== 20'd70) begin n_err++; $display("FAIL len4_result got %0d want 70", tr_res[7]); end
    endtask

    task automatic test_wrap();
        logic [ACCW-1:0] exp_res;
        logic [AW-1:0]   exp_a;
        mem_a[14] = 8'h03; mem_a[15] = 8'h09; mem_a[0] = 8'h10; mem_a[1] = 8'h7F;
        mem_b[2]  = 8'h02; mem_b[3]  = 8'h80; mem_b[4] = 8'h05; mem_b[5] = 8'h81;
        exp_res = model(4, 14, 2);
        do_start(4, 14, 2);
        record(9, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            exp_a = AW'(13 + c);
            n_cmp++;
            if (tr_aa[c] !== exp_a || tr_ab[c] !== AW'(1 + c)) begin
                n_err++; $display("FAIL wrap_addr_c%0d got a=%0d b=%0d want a=%0d b=%0d", c, tr_aa[c], tr_ab[c], exp_a, 1 + c);
            end
        end
        n_cmp++; if (tr_aa[6] !== 4'd1 || tr_ab[6] !== 4'd5) begin n_err++; $display("FAIL wrap_addr_hold got %0d/%0d want 1/5", tr_aa[6], tr_ab[6]); end
        n_cmp++; if (first_done(9) !== 7) begin n_err++; $display("FAIL wrap_done_cycle got %0d want 7", first_done(9)); end
        n_cmp++; if (tr_res[7] !== exp_res) begin n_err++; $display("FAIL wrap_result got %h want %h", tr_res[7], exp_res); end
    endtask

    task automatic test_full();
        logic [ACCW-1:0] exp_res;
`ifdef DOTP_SIGNED_EN
        exp_res = 20'd16;
`else
        exp_res = 20'hFE010;
`endif
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        do_start(16, 0, 0);
        record(21, 0, 0, 0);
        n_cmp++; if (tr_aa[16] !== 4'd15 || tr_en[16] !== 1'b1 || tr_en[17] !== 1'b0) begin n_err++; $display("FAIL full_last_read got a=%0d en16=%b en17=%b want 15/1/0", tr_aa[16], tr_en[16], tr_en[17]); end
        n_cmp++; if (first_done(21) !== 19) begin n_err++; $display("FAIL full_done_cycle got %0d want 19", first_done(21)); end
        n_cmp++; if (tr_res[19] !== exp_res) begin n_err++; $display("FAIL full_result got %h want %h", tr_res[19], exp_res); end
    endtask

    task automatic test_zero();
        logic any_en, any_busy;
        do_start(0, 5, 5);
        record(4, 0, 0, 0);
        any_en = 1'b0; any_busy = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            any_en   = any_en | tr_en[c];
            any_busy = any_busy | tr_busy[c];
        end
        n_cmp++; if (first_done(4) !== 1) begin n_err++; $display("FAIL zero_done_cycle got %0d want 1", first_done(4)); end
        n_cmp++; if (tr_res[1] !== '0) begin n_err++; $display("FAIL zero_result got %h want 0", tr_res[1]); end
        n_cmp++; if (any_en !== 1'b0) begin n_err++; $display("FAIL zero_rd_en got %b want 0", any_en); end
        n_cmp++; if (any_busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b want 0", any_busy); end
    endtask

    task automatic test_back_to_back();
        mem_a[0] = 8'h11; mem_a[1] = 8'h02;
        mem_b[0] = 8'h22; mem_b[1] = 8'h03;
        do_start(1, 0, 0);
        record(11, 4, 2, 0);
        n_cmp++; if (tr_done[4] !== 1'b1 || tr_res[4] !== 20'h00242) begin n_err++; $display("FAIL b2b_first got done=%b res=%h want 1/00242", tr_done[4], tr_res[4]); end
        n_cmp++; if (tr_en[5] !== 1'b1 || tr_en[6] !== 1'b1 || tr_en[7] !== 1'b0) begin n_err++; $display("FAIL b2b_rd_en got %b%b%b want 110", tr_en[5], tr_en[6], tr_en[7]); end
        n_cmp++; if (tr_res[8] !== 20'h00242) begin n_err++; $display("FAIL b2b_result_hold got %h want 00242", tr_res[8]); end
        n_cmp++; if (tr_done[9] !== 1'b1 || count_done(11) !== 2) begin n_err++; $display("FAIL b2b_second_done got done9=%b count=%0d want 1/2", tr_done[9], count_done(11)); end
        n_cmp++; if (tr_res[9] !== 20'd584) begin n_err++; $display("FAIL b2b_second_result got %0d want 584", tr_res[9]); end
    endtask

    task automatic test_start_during_read();
        logic any_late_en;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        do_start(4, 0, 0);
        record(10, 2, 2, 8);
        any_late_en = 1'b0;
        for (int c = 5; c <= 10; c++) any_late_en = any_late_en | tr_en[c];
        n_cmp++; if (tr_aa[3] !== 4'd2) begin n_err++; $display("FAIL ignore_addr got %0d want 2", tr_aa[3]); end
        n_cmp++; if (tr_res[6] !== 20'd584) begin n_err++; $display("FAIL ignore_result_hold got %0d want 584", tr_res[6]); end
        n_cmp++; if (any_late_en !== 1'b0) begin n_err++; $display("FAIL ignore_extra_reads got %b want 0", any_late_en); end
        n_cmp++; if (first_done(10) !== 7 || count_done(10) !== 1) begin n_err++; $display("FAIL ignore_done got cycle=%0d count=%0d want 7/1", first_done(10), count_done(10)); end
        n_cmp++; if (tr_res[7] !== 20'd70) begin n_err++; $display("FAIL ignore_result got %0d want 70", tr_res[7]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        do_start(8, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rd_en_a !== 1'b0 || rd_en_b !== 1'b0) begin n_err++; $display("FAIL rstmid_rd_en got %b%b want 00", rd_en_a, rd_en_b); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_busy_done got %b/%b want 0/0", busy, done); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL rstmid_result got %h want 0", result); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL rstmid_state got %0d want IDLE", dbg_state); end
        rst = 1'b0;
        do_start(4, 0, 0);
        record(10, 0, 0, 0);
        n_cmp++; if (tr_en[1] !== 1'b1 || tr_aa[1] !== 4'd0) begin n_err++; $display("FAIL rstmid_restart got en=%b a=%0d want 1/0", tr_en[1], tr_aa[1]); end
        n_cmp++; if (first_done(10) !== 7 || count_done(10) !== 1) begin n_err++; $display("FAIL rstmid_done got cycle=%0d count=%0d want 7/1", first_done(10), count_done(10)); end
        n_cmp++; if (tr_res[7] !== 20'd70) begin n_err++; $display("FAIL rstmid_result_after got %0d want 70", tr_res[7]); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_len4();
        test_wrap();
        test_full();
        test_zero();
        test_back_to_back();
        test_start_during_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dotp_engine.md
# dotp_engine

- Read-side initiator for a pair of `mem1` operand memories in the dot-product datapath.
- On `start`, streams `len` element pairs from memory A and memory B through the synchronous read ports, multiplies each pair and accumulates the products.
- Presents the sum on `result` with a one-cycle `done` pulse.
- Drives `mem1`'s `read_en`/`read_address` and consumes its registered `data_out` (one-cycle read latency).

## Interface
- `DATA_WIDTH`, 8, operand width (matches `mem1` data width)
- `ADDR_WIDTH`, 4, memory address width; max vector length is 2^ADDR_WIDTH
- `ACC_WIDTH`, 2*DATA_WIDTH+ADDR_WIDTH, accumulator/result width
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only when `busy`=0
- `len`  in  ADDR_WIDTH+1  element count 0..2^ADDR_WIDTH, sampled with `start`
- `base_a`  in  ADDR_WIDTH  first address in memory A, sampled with `start`
- `base_b`  in  ADDR_WIDTH  first address in memory B, sampled with `start`
- `rd_en_a`, `rd_en_b`  out  1  read enables to memories A/B
- `rd_addr_a`, `rd_addr_b`  out  ADDR_WIDTH  read addresses
- `rd_data_a`, `rd_data_b`  in  DATA_WIDTH  registered memory outputs, valid the cycle after the matching `rd_en`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, `result` valid
- `result`  out  ACC_WIDTH  dot product, held until the next accepted `start`

## Operation
- FSM states and transitions:
  - IDLE: `start`&&`len`!=0 -> READ; `start`&&`len`==0 -> DONE with acc=0.
  - READ: issues reads for `len` cycles -> DRAIN.
  - DRAIN: 2 cycles -> DONE.
  - DONE: 1 cycle -> IDLE, or -> READ/DONE if `start` is accepted that cycle.
- `start` accepted in IDLE and DONE. Ignored in READ and DRAIN, with no side effects.
- On accept: latch `len`, `base_a`, `base_b`; clear the accumulator.
- READ: `rd_en_a`=`rd_en_b`=1 every cycle. Addresses are `base_x`+i for i=0..len-1, modulo 2^ADDR_WIDTH (wrap 15->0 at default width).
- Pipeline:
  - valid flag = `rd_en` delayed one cycle.
  - Stage 1: product register p = `rd_data_a`*`rd_data_b`, full 2*DATA_WIDTH width.
  - Stage 2: acc += p, extended to ACC_WIDTH; wraps modulo 2^ACC_WIDTH if overridden narrower.
- `rd_addr_x` hold their last value when `rd_en` is low.
- Reset values: state IDLE; `rd_en_a`, `rd_en_b`, `busy`, `done` = 0; `rd_addr_a`, `rd_addr_b` = 0; `result` = 0; acc and pipeline flags = 0.
- Reset mid-operation: all state returns to reset values at the next edge. `rd_en` is low in the following cycle and no `done` is produced. A `start` the cycle after reset release is accepted.

## Timing
- Cycle 0: `start` sampled.
- Cycles 1..len: `rd_en`=1.
- Cycle len+1: data returned.
- End of len+1: product registered.
- End of len+2: accumulate.
- Cycle len+3: `done`=1 and `result` updated. Start-to-done = len+3 cycles.
- len=0: `done` in cycle 1, `result`=0, no reads issued.
- `busy`=1 in cycles 1..len+2 and 0 in the `done` cycle. Back-to-back `start` in the `done` cycle puts `rd_en` high in the next cycle.
- `result` updates only in the `done` cycle; stable otherwise.

## Configuration
- `DOTP_SIGNED_EN` defined: operands, product and accumulation are two's complement, sign-extended to ACC_WIDTH.
- Undefined: all arithmetic is unsigned, zero-extended.
- Interface and timing are identical in both builds.

## Structure
- Package `dotp_pkg`:
  - FSM state enum (IDLE, READ, DRAIN, DONE)
  - default DATA_WIDTH/ADDR_WIDTH
  - ACC_WIDTH derivation
  - DRAIN length constant (2)
- Sub-module `dotp_mac`: valid-qualified multiply register plus accumulator with synchronous clear. It contains the `DOTP_SIGNED_EN` switch.
- Top level holds the FSM, element counter and address generators.

## Test plan
Bench pairs the engine with two `mem1` instances (`rst_n` = ~`rst`), preloaded through their write ports.
- len=1, A[0]=0x11, B[0]=0x22 -> `rd_en` only in cycle 1; `done` in cycle 4; `result`=0x242.
- len=4, A[0..3]=1,2,3,4, B[0..3]=5,6,7,8 -> `rd_addr` 0,1,2,3 in consecutive cycles; `result`=70; `busy` high for cycles 1..6.
- base_a=14, base_b=2, len=4 -> `rd_addr_a` 14,15,0,1 and `rd_addr_b` 2,3,4,5; `result` matches the model.
- len=16, all operands 0xFF -> unsigned build `result`=0xFE010; `DOTP_SIGNED_EN` build `result`=16.
- len=0 -> `done` in cycle 1, `result`=0, `rd_en` never high.
- Boundary cases:
  - `start` during READ -> ignored, `result` unchanged.
  - `rst` in cycle 2 of a len=8 run -> next cycle `rd_en`=0, `busy`=0, `result`=0, no `done`.
  - A following `start` completes correctly.
